// File: rtl/breakout_engine.sv
// breakout_engine: per-frame game state for the breakout demo.
// Paddle motion, ball motion/reflection and serve/play/lost/over FSM.
module breakout_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER       = 8,
  parameter int BALL_R       = 4,
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_Y     = 448,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       frame_pulse,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       block_hit,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [9:0] paddle_x,
  output logic [2:0] lives,
  output logic [1:0] state,
  output logic       lost_pulse
);

  typedef enum logic [1:0] {
    S_SERVE = 2'b00,
    S_PLAY  = 2'b01,
    S_LOST  = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  localparam logic signed [10:0] PX_MIN =
    11'(BORDER + PADDLE_W / 2);
  localparam logic signed [10:0] PX_MAX =
    11'(H_ACTIVE - BORDER - PADDLE_W / 2);
  localparam logic signed [10:0] BX_MIN =
    11'(BORDER + BALL_R);
  localparam logic signed [10:0] BX_MAX =
    11'(H_ACTIVE - BORDER - BALL_R);
  localparam logic signed [10:0] BY_MIN =
    11'(BORDER + BALL_R);
  localparam logic signed [10:0] BY_REST =
    11'(PADDLE_Y - BALL_R);
  localparam logic signed [10:0] PSPD  = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] BSPD  = 11'(BALL_SPEED);
  localparam logic signed [10:0] RAD   = 11'(BALL_R);
  localparam logic signed [10:0] VACT  = 11'(V_ACTIVE);
  localparam logic signed [10:0] MID   = 11'(H_ACTIVE / 2);
  localparam logic signed [10:0] CATCH =
    11'(PADDLE_W / 2 + BALL_R);
  localparam logic [2:0] LIVES3 = 3'(LIVES);

  state_e r_state, w_state_nx;

  logic signed [10:0] r_px, r_bx, r_by;
  logic signed [10:0] w_px_nx, w_bx_nx, w_by_nx;
  logic signed [10:0] w_px_mv, w_nx, w_ny;
  logic signed [10:0] w_dist, w_adist;
  logic [2:0] r_lives, w_lives_nx;
  logic r_dx, r_dy, r_hit, r_lost;
  logic w_dx_nx, w_dy_nx, w_hit_nx, w_lost_nx;
  logic w_hit, w_dy_eff, w_top, w_catch, w_lose;
  logic w_unused;

  // Candidate moves, shared by the FSM and datapath.
  always_comb begin
    w_hit   = r_hit | block_hit;
    w_px_mv = r_px;
    if (btn_left && !btn_right)
      w_px_mv = (r_px - PSPD <= PX_MIN) ?
                PX_MIN : r_px - PSPD;
    else if (btn_right && !btn_left)
      w_px_mv = (r_px + PSPD >= PX_MAX) ?
                PX_MAX : r_px + PSPD;
    w_dy_eff = r_dy ^ w_hit;
    w_nx     = r_dx ? r_bx + BSPD : r_bx - BSPD;
    w_ny     = w_dy_eff ? r_by + BSPD : r_by - BSPD;
    w_dist   = w_nx - r_px;
    w_adist  = w_dist[10] ? -w_dist : w_dist;
    w_top    = (w_ny <= BY_MIN);
    w_catch  = w_dy_eff && (r_by <= BY_REST) &&
               (w_ny >= BY_REST) && (w_adist <= CATCH);
    w_lose   = !w_top && !w_catch &&
               (w_ny + RAD >= VACT);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_SERVE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (frame_pulse) begin
      unique case (1'b1)
        (r_state == S_SERVE):
          if (btn_select) w_state_nx = S_PLAY;
        (r_state == S_PLAY):
          if (w_lose) w_state_nx = S_LOST;
        (r_state == S_LOST):
          w_state_nx = (r_lives == 3'd0) ?
                       S_OVER : S_SERVE;
        default:
          if (btn_select) w_state_nx = S_SERVE;
      endcase
    end
  end

  always_comb begin
    w_px_nx    = r_px;
    w_bx_nx    = r_bx;
    w_by_nx    = r_by;
    w_dx_nx    = r_dx;
    w_dy_nx    = r_dy;
    w_lives_nx = r_lives;
    w_lost_nx  = 1'b0;
    w_hit_nx   = w_hit;
    if (frame_pulse) begin
      w_hit_nx = 1'b0;
      if (r_state != S_OVER) w_px_nx = w_px_mv;
      unique case (1'b1)
        (r_state == S_SERVE): begin
          w_bx_nx = w_px_mv;
          w_by_nx = BY_REST;
          if (btn_select) begin
            w_dx_nx = 1'b1;
            w_dy_nx = 1'b0;
          end
        end
        (r_state == S_PLAY): begin
          // A lost ball stays where it was last drawn.
          if (w_lose) begin
            w_lives_nx = r_lives - 3'd1;
            w_lost_nx  = 1'b1;
          end else begin
            w_dy_nx = w_dy_eff;
            if (w_nx <= BX_MIN) begin
              w_bx_nx = BX_MIN;
              w_dx_nx = 1'b1;
            end else if (w_nx >= BX_MAX) begin
              w_bx_nx = BX_MAX;
              w_dx_nx = 1'b0;
            end else begin
              w_bx_nx = w_nx;
            end
            if (w_top) begin
              w_by_nx = BY_MIN;
              w_dy_nx = 1'b1;
            end else if (w_catch) begin
              w_by_nx = BY_REST;
              w_dy_nx = 1'b0;
            end else begin
              w_by_nx = w_ny;
            end
          end
        end
        (r_state == S_LOST): begin
        end
        default:
          if (btn_select) begin
            w_lives_nx = LIVES3;
            w_px_nx    = MID;
          end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_px    <= MID;
      r_bx    <= MID;
      r_by    <= BY_REST;
      r_dx    <= 1'b1;
      r_dy    <= 1'b0;
      r_hit   <= 1'b0;
      r_lost  <= 1'b0;
      r_lives <= LIVES3;
    end else begin
      r_px    <= w_px_nx;
      r_bx    <= w_bx_nx;
      r_by    <= w_by_nx;
      r_dx    <= w_dx_nx;
      r_dy    <= w_dy_nx;
      r_hit   <= w_hit_nx;
      r_lost  <= w_lost_nx;
      r_lives <= w_lives_nx;
    end
  end

  assign ball_x     = r_bx[9:0];
  assign ball_y     = r_by[8:0];
  assign paddle_x   = r_px[9:0];
  assign lives      = r_lives;
  assign state      = r_state;
  assign lost_pulse = r_lost;

  assign w_unused = ^{r_bx[10], r_by[10:9], r_px[10]};

endmodule

// File: tb/tb_breakout_engine.sv
// tb_breakout_engine: directed frames against a frame-level model
// of the game rules, plus hand-computed anchor values.
module tb_breakout_engine;

  localparam int H      = 640;
  localparam int V      = 480;
  localparam int BRD    = 8;
  localparam int R      = 4;
  localparam int PW     = 64;
  localparam int PY     = 448;
  localparam int PSPD   = 4;
  localparam int BSPD   = 2;
  localparam int NLIVES = 3;

  localparam int PXMIN  = BRD + PW / 2;
  localparam int PXMAX  = H - BRD - PW / 2;
  localparam int BXMIN  = BRD + R;
  localparam int BXMAX  = H - BRD - R;
  localparam int BYMIN  = BRD + R;
  localparam int BYREST = PY - R;

  typedef struct packed {
    int px;
    int bx;
    int by;
    int vx;
    int vy;
    int st;
    int lives;
    bit lost;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_pulse, block_hit;
  logic       btn_left, btn_right, btn_select;
  logic [9:0] ball_x, paddle_x;
  logic [8:0] ball_y;
  logic [2:0] lives;
  logic [1:0] state;
  logic       lost_pulse;

  int      n_checks = 0;
  int      n_fail   = 0;
  bit      chk_en   = 1'b0;
  bit      lp_seen;
  mstate_t m;
  bit      m_hit;

  breakout_engine dut (
    .clk        (clk),
    .nRst       (rst_n),
    .frame_pulse(frame_pulse),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_select (btn_select),
    .block_hit  (block_hit),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_x   (paddle_x),
    .lives      (lives),
    .state      (state),
    .lost_pulse (lost_pulse)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // One frame of the game rules, with velocities as signed ints.
  function automatic mstate_t step(mstate_t s, bit l, bit r,
                                   bit sel, bit hit);
    mstate_t n;
    int nx, ny, mv;
    n = s;
    n.lost = 1'b0;
    mv = (l && !r) ? -PSPD : (r && !l) ? PSPD : 0;
    if (s.st != 3) n.px = clampi(s.px + mv, PXMIN, PXMAX);
    case (s.st)
      0: begin
        n.bx = n.px;
        n.by = BYREST;
        if (sel) begin
          n.st = 1;
          n.vx = BSPD;
          n.vy = -BSPD;
        end
      end
      1: begin
        if (hit) n.vy = -s.vy;
        nx = s.bx + n.vx;
        ny = s.by + n.vy;
        n.bx = clampi(nx, BXMIN, BXMAX);
        if (nx <= BXMIN) n.vx = BSPD;
        else if (nx >= BXMAX) n.vx = -BSPD;
        if (ny <= BYMIN) begin
          n.by = BYMIN;
          n.vy = BSPD;
        end else if (n.vy > 0 && s.by <= BYREST &&
                     ny >= BYREST &&
                     iabs(nx - s.px) <= PW / 2 + R) begin
          n.by = BYREST;
          n.vy = -BSPD;
        end else if (ny + R >= V) begin
          n.bx = s.bx;
          n.by = s.by;
          n.vx = s.vx;
          n.vy = s.vy;
          n.st = 2;
          n.lives = s.lives - 1;
          n.lost = 1'b1;
        end else begin
          n.by = ny;
        end
      end
      2: n.st = (s.lives == 0) ? 3 : 0;
      default:
        if (sel) begin
          n.lives = NLIVES;
          n.px = H / 2;
          n.st = 0;
        end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{px: H / 2, bx: H / 2, by: BYREST, vx: BSPD,
             vy: -BSPD, st: 0, lives: NLIVES, lost: 1'b0};
      m_hit <= 1'b0;
    end else if (frame_pulse) begin
      m <= step(m, btn_left, btn_right, btn_select,
                m_hit | block_hit);
      m_hit <= 1'b0;
    end else begin
      m.lost <= 1'b0;
      if (block_hit) m_hit <= 1'b1;
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ball_x", int'(ball_x), m.bx);
      check("ball_y", int'(ball_y), m.by);
      check("paddle_x", int'(paddle_x), m.px);
      check("lives", int'(lives), m.lives);
      check("state", int'(state), m.st);
      check("lost_pulse", int'(lost_pulse), int'(m.lost));
    end
  end

  task automatic frame(input bit l, input bit r,
                       input bit s, input bit h);
    btn_left    = l;
    btn_right   = r;
    btn_select  = s;
    block_hit   = h;
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    btn_select  = 1'b0;
    block_hit   = 1'b0;
    lp_seen     = lost_pulse;
    @(negedge clk);
  endtask

  task automatic pin_ball(input string name, input int x,
                          input int y);
    check({name, "_x"}, int'(ball_x), x);
    check({name, "_y"}, int'(ball_y), y);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    frame_pulse = 1'b0;
    block_hit = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_select = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pin_ball("reset", 320, 444);
    check("reset_paddle", int'(paddle_x), 320);
    check("reset_lives", int'(lives), 3);
    check("reset_state", int'(state), 0);
    check("reset_lost", int'(lost_pulse), 0);

    repeat (70) frame(1, 0, 0, 0);
    check("clamp_left", int'(paddle_x), 40);
    check("serve_track", int'(ball_x), 40);
    frame(1, 0, 0, 0);
    check("clamp_left71", int'(paddle_x), 40);
    frame(1, 1, 0, 0);
    check("both_btn", int'(paddle_x), 40);

    repeat (145) frame(0, 1, 0, 0);
    check("clamp_right", int'(paddle_x), 600);
    pin_ball("serve_pos", 600, 444);

    frame(0, 0, 1, 0);
    check("serve_state", int'(state), 1);
    frame(0, 0, 0, 0);
    pin_ball("play_f1", 602, 442);
    repeat (13) frame(0, 0, 0, 0);
    pin_ball("wall_f14", 628, 416);
    frame(0, 0, 0, 0);
    pin_ball("wall_f15", 626, 414);

    repeat (4) @(negedge clk);
    block_hit = 1'b1;
    @(negedge clk);
    block_hit = 1'b0;
    frame(0, 0, 0, 0);
    pin_ball("hit_f16", 624, 416);
    repeat (14) frame(0, 0, 0, 0);
    pin_ball("catch", 596, 444);
    frame(0, 0, 0, 0);
    pin_ball("after_catch", 594, 442);
    repeat (2) frame(0, 0, 0, 0);
    frame(0, 0, 0, 1);
    pin_ball("hit_same", 588, 440);
    frame(0, 0, 0, 0);
    pin_ball("hit_once", 586, 442);

    for (int life = 0; life < 3; life++) begin
      if (life > 0) frame(0, 0, 1, 0);
      for (int f = 0; f < 3000 && m.st != 2; f++)
        frame(m.bx >= m.px, m.bx < m.px, 0, 0);
      check("loss_state", int'(state), 2);
      check("loss_lives", int'(lives), 2 - life);
      check("loss_pulse", int'(lp_seen), 1);
      check("pulse_gone", int'(lost_pulse), 0);
      frame(0, 0, 0, 0);
      check("post_loss", int'(state), (life == 2) ? 3 : 0);
    end

    frame(1, 0, 0, 0);
    check("over_hold", int'(state), 3);
    frame(0, 0, 1, 0);
    check("restart_state", int'(state), 0);
    check("restart_lives", int'(lives), 3);
    check("restart_paddle", int'(paddle_x), 320);
    frame(0, 0, 0, 0);
    pin_ball("restart_ball", 320, 444);

    frame(0, 0, 1, 0);
    repeat (5) frame(0, 1, 0, 0);
    check("midplay_state", int'(state), 1);
    #2 rst_n = 1'b0;
    #1;
    pin_ball("async_rst", 320, 444);
    check("async_paddle", int'(paddle_x), 320);
    check("async_state", int'(state), 0);
    check("async_lives", int'(lives), 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
